// File: rtl/reg_bus_poller.sv
// ============================================================================
// Module : reg_bus_poller
// Brief  : REG_BUS initiator that sweeps the bit-flip monitor's status
//          registers and raises an alarm on the latest committed snapshot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_bus_poller #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 32,
  parameter int PERIOD_W   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [PERIOD_W-1:0]   period_i,
  input  logic [DATA_WIDTH-1:0] threshold_i,
  input  logic                  clr_err_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  ready_i,
  input  logic                  error_i,
  output logic                  flag_o,
  output logic [DATA_WIDTH-1:0] cpbf_o,
  output logic                  update_o,
  output logic                  alarm_o,
  output logic                  bus_err_o
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic [2:0]            state_q,   state_d;
  logic                  idx_q,     idx_d;
  logic [TCNT_W-1:0]     tcnt_q,    tcnt_d;
  logic [PERIOD_W-1:0]   wcnt_q,    wcnt_d;
  logic [DATA_WIDTH-1:0] shadow0_q, shadow0_d;
  logic [DATA_WIDTH-1:0] shadow1_q, shadow1_d;
  logic                  flag_q,    flag_d;
  logic [DATA_WIDTH-1:0] cpbf_q,    cpbf_d;
  logic                  alarm_q,   alarm_d;
  logic                  bus_err_q, bus_err_d;

  logic w_timeout;
  logic w_req_err;
  logic w_req_ok;
  logic w_commit;

  // A response arriving on the TIMEOUT-th REQ cycle is still accepted.
  assign w_timeout = (tcnt_q == TCNT_W'(TIMEOUT));
  assign w_req_err = (state_q == S_REQ) && (error_i || (!ready_i && w_timeout));
  assign w_req_ok  = (state_q == S_REQ) && ready_i && !error_i;
  assign w_commit  = (state_q == S_GAP) && idx_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      idx_q     <= 1'b0;
      tcnt_q    <= '0;
      wcnt_q    <= '0;
      shadow0_q <= '0;
      shadow1_q <= '0;
      flag_q    <= 1'b0;
      cpbf_q    <= '0;
      alarm_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      wcnt_q    <= wcnt_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      flag_q    <= flag_d;
      cpbf_q    <= cpbf_d;
      alarm_q   <= alarm_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          idx_d   = 1'b0;
          tcnt_d  = TCNT_W'(1);
        end
      end
      S_REQ: begin
        if (w_req_err) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
          wcnt_d  = PERIOD_W'(1);
        end else if (ready_i) begin
          state_d = S_GAP;
          tcnt_d  = '0;
        end else begin
          tcnt_d  = tcnt_q + TCNT_W'(1);
        end
      end
      S_GAP: begin
        if (!idx_q) begin
          state_d = S_REQ;
          idx_d   = 1'b1;
          tcnt_d  = TCNT_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_WAIT;
          wcnt_d  = PERIOD_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A period of 0 behaves like 1: the request follows the first WAIT cycle.
        if (!start_i) begin
          state_d = S_IDLE;
        end else if (wcnt_q >= period_i) begin
          state_d = S_REQ;
          idx_d   = 1'b0;
          tcnt_d  = TCNT_W'(1);
        end else begin
          wcnt_d  = wcnt_q + PERIOD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Snapshot is committed on the GAP->DONE edge so it is visible alongside update_o.
  always_comb begin
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    flag_d    = flag_q;
    cpbf_d    = cpbf_q;
    alarm_d   = alarm_q;
    bus_err_d = bus_err_q;
    if (w_req_ok) begin
      if (idx_q) shadow1_d = rdata_i;
      else       shadow0_d = rdata_i;
    end
    if (w_commit) begin
      flag_d  = shadow0_q[0];
      cpbf_d  = shadow1_q;
      alarm_d = shadow0_q[0] || ((shadow1_q != '0) && (shadow1_q < threshold_i));
    end
    if (w_req_err)      bus_err_d = 1'b1;
    else if (clr_err_i) bus_err_d = 1'b0;
  end

  always_comb begin
    valid_o   = (state_q == S_REQ);
    addr_o    = ADDR_WIDTH'(idx_q);
    update_o  = (state_q == S_DONE);
    flag_o    = flag_q;
    cpbf_o    = cpbf_q;
    alarm_o   = alarm_q;
    bus_err_o = bus_err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_poller.sv
// ============================================================================
// Module : tb_reg_bus_poller
// Brief  : Self-checking bench for reg_bus_poller with a scripted responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_bus_poller;

  localparam int DW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [PW-1:0] period;
  logic [DW-1:0] threshold;
  logic          clr_err;
  logic          valid;
  logic          addr;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          error;
  logic          flag;
  logic [DW-1:0] cpbf;
  logic          update;
  logic          alarm;
  logic          bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bus_poller #(.ADDR_WIDTH(1), .DATA_WIDTH(DW), .PERIOD_W(PW), .TIMEOUT(15)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .period_i(period),
    .threshold_i(threshold), .clr_err_i(clr_err), .valid_o(valid), .addr_o(addr),
    .rdata_i(rdata), .ready_i(ready), .error_i(error), .flag_o(flag), .cpbf_o(cpbf),
    .update_o(update), .alarm_o(alarm), .bus_err_o(bus_err)
  );

  // Responder: 0 normal, 1 silent, 2 error on err_addr, 3 ready+error on err_addr.
  // A request still held after its reply gets a stale ready with junk data.
  int            resp_mode = 0;
  int            err_addr  = 0;
  logic [DW-1:0] mem [2];
  logic          smp_v = 1'b0;
  logic          smp_a = 1'b0;
  bit            given = 1'b0;

  always @(negedge clk) begin
    smp_v = valid;
    smp_a = addr;
  end

  always @(posedge clk) begin
    #1;
    ready = 1'b0;
    error = 1'b0;
    rdata = $urandom;
    if (smp_v !== 1'b1) begin
      given = 1'b0;
    end else if (!given) begin
      if (resp_mode != 1) begin
        given = 1'b1;
        if (resp_mode == 2 && int'(smp_a) == err_addr) begin
          error = 1'b1; rdata = 32'hDEADBEEF;
        end else if (resp_mode == 3 && int'(smp_a) == err_addr) begin
          error = 1'b1; ready = 1'b1; rdata = 32'hDEADBEEF;
        end else begin
          ready = 1'b1; rdata = mem[smp_a];
        end
      end
    end else begin
      ready = 1'b1;
      rdata = 32'hBAD00001;
    end
  end

  function automatic bit model_alarm(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                     input logic [DW-1:0] th);
    return (d0[0] == 1'b1) || ((d1 != 0) && (d1 < th));
  endfunction

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One sweep with start dropped right after the first request; cycle 1 = valid rise.
  task automatic do_sweep(output bit rose, output int n_upd, output int lat);
    int cyc;
    n_upd = 0;
    lat   = 0;
    start = 1'b1;
    wait_valid(10, rose);
    start = 1'b0;
    cyc = 1;
    repeat (40) begin
      @(negedge clk);
      cyc++;
      if (update === 1'b1) begin
        n_upd++;
        if (lat == 0) lat = cyc;
      end
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; period = '0; threshold = '0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (addr !== 1'b0)    begin n_fail++; $display("FAIL reset_addr got %b want 0", addr); end
    n_checks++; if (update !== 1'b0)  begin n_fail++; $display("FAIL reset_update got %b want 0", update); end
    n_checks++; if (flag !== 1'b0)    begin n_fail++; $display("FAIL reset_flag got %b want 0", flag); end
    n_checks++; if (cpbf !== '0)      begin n_fail++; $display("FAIL reset_cpbf got %h want 0", cpbf); end
    n_checks++; if (alarm !== 1'b0)   begin n_fail++; $display("FAIL reset_alarm got %b want 0", alarm); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL idle_valid got %b want 0", valid); end
  endtask

  task automatic test_nominal();
    bit ok;
    int cyc, n;
    mem[0] = 32'h0; mem[1] = 32'h40; threshold = 32'h50; period = 16'd4; resp_mode = 0;
    start = 1'b1;
    wait_valid(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nom_first_req got none want valid within 10"); end
    cyc = 1;
    while (cyc < 40 && update !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc != 7)         begin n_fail++; $display("FAIL nom_update_cycle got %0d want 7", cyc); end
    n_checks++; if (flag !== 1'b0)    begin n_fail++; $display("FAIL nom_flag got %b want 0", flag); end
    n_checks++; if (cpbf !== 32'h40)  begin n_fail++; $display("FAIL nom_cpbf got %h want 40", cpbf); end
    n_checks++; if (alarm !== model_alarm(mem[0], mem[1], threshold))
      begin n_fail++; $display("FAIL nom_alarm got %b want 1", alarm); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid === 1'b1) break;
      n++;
    end
    n_checks++; if (n != 4)        begin n_fail++; $display("FAIL nom_wait_cycles got %0d want 4", n); end
    n_checks++; if (addr !== 1'b0) begin n_fail++; $display("FAIL nom_next_addr got %b want 0", addr); end
    start = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_alarm_cases();
    logic [DW-1:0] t0 [3] = '{32'h1, 32'h0, 32'h0};
    logic [DW-1:0] t1 [3] = '{32'h80, 32'h0, 32'h80};
    bit rose;
    int n_upd, lat;
    threshold = 32'h50;
    for (int k = 0; k < 3; k++) begin
      mem[0] = t0[k]; mem[1] = t1[k];
      do_sweep(rose, n_upd, lat);
      n_checks++; if (!rose || n_upd != 1)
        begin n_fail++; $display("FAIL alarm%0d_updates got %0d want 1", k, n_upd); end
      n_checks++; if (alarm !== model_alarm(t0[k], t1[k], threshold))
        begin n_fail++; $display("FAIL alarm%0d_alarm got %b want %b", k, alarm, model_alarm(t0[k], t1[k], threshold)); end
      n_checks++; if (cpbf !== t1[k] || flag !== t0[k][0])
        begin n_fail++; $display("FAIL alarm%0d_snapshot got %h/%b want %h/%b", k, cpbf, flag, t1[k], t0[k][0]); end
    end
  endtask

  task automatic test_error();
    bit rose, ok;
    int n_upd, lat, n, ups;
    mem[0] = 32'h0; mem[1] = 32'h40; period = 16'd4;
    do_sweep(rose, n_upd, lat);
    n_checks++; if (cpbf !== 32'h40) begin n_fail++; $display("FAIL err_pre_cpbf got %h want 40", cpbf); end
    resp_mode = 2; err_addr = 1;
    start = 1'b1;
    ups = 0; ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (update === 1'b1) ups++;
      if (valid === 1'b1 && addr === 1'b1) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < 20 && valid === 1'b1; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid === 1'b1) break;
      if (update === 1'b1) ups++;
      n++;
      @(negedge clk);
    end
    n_checks++; if (!ok)               begin n_fail++; $display("FAIL err_addr1_req got none want request"); end
    n_checks++; if (bus_err !== 1'b1)  begin n_fail++; $display("FAIL err_bus_err got %b want 1", bus_err); end
    n_checks++; if (ups != 0)          begin n_fail++; $display("FAIL err_update got %0d want 0", ups); end
    n_checks++; if (cpbf !== 32'h40)   begin n_fail++; $display("FAIL err_cpbf got %h want 40", cpbf); end
    n_checks++; if (n != 4)            begin n_fail++; $display("FAIL err_wait got %0d want 4", n); end
    n_checks++; if (addr !== 1'b0)     begin n_fail++; $display("FAIL err_retry_addr got %b want 0", addr); end
    start = 1'b0;
    repeat (40) @(negedge clk);
    resp_mode = 0;
    pulse_clr();
    n_checks++; if (bus_err !== 1'b0)  begin n_fail++; $display("FAIL err_clear got %b want 0", bus_err); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    resp_mode = 1; period = 16'd4;
    start = 1'b1;
    wait_valid(10, ok);
    start = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid !== 1'b1) break;
      n++;
    end
    n_checks++; if (!ok || n != 15)   begin n_fail++; $display("FAIL to_valid_len got %0d want 15", n); end
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err got %b want 1", bus_err); end
    repeat (20) @(negedge clk);
    pulse_clr();
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b want 0", bus_err); end
    start = 1'b1;
    wait_valid(10, ok);
    start = 1'b0;
    for (int i = 1; i < 15; i++) @(negedge clk);
    n_checks++; if (bus_err !== 1'b0 || valid !== 1'b1)
      begin n_fail++; $display("FAIL to_pre_coincide got err=%b valid=%b want 0/1", bus_err, valid); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_set_wins got %b want 1", bus_err); end
    repeat (20) @(negedge clk);
    pulse_clr();
    resp_mode = 0;
  endtask

  task automatic test_both_and_stale();
    bit rose;
    int n_upd, lat;
    mem[0] = 32'h0; mem[1] = 32'h77;
    do_sweep(rose, n_upd, lat);
    n_checks++; if (cpbf !== 32'h77) begin n_fail++; $display("FAIL both_pre_cpbf got %h want 77", cpbf); end
    resp_mode = 3; err_addr = 0; mem[0] = 32'h1; mem[1] = 32'h99;
    do_sweep(rose, n_upd, lat);
    n_checks++; if (n_upd != 0)        begin n_fail++; $display("FAIL both_update got %0d want 0", n_upd); end
    n_checks++; if (bus_err !== 1'b1)  begin n_fail++; $display("FAIL both_bus_err got %b want 1", bus_err); end
    n_checks++; if (cpbf !== 32'h77 || flag !== 1'b0)
      begin n_fail++; $display("FAIL both_no_capture got %h/%b want 77/0", cpbf, flag); end
    resp_mode = 0;
    pulse_clr();
    mem[0] = 32'h110; mem[1] = 32'h222;
    do_sweep(rose, n_upd, lat);
    n_checks++; if (n_upd != 1 || lat != 7)
      begin n_fail++; $display("FAIL stale_update got n=%0d lat=%0d want 1/7", n_upd, lat); end
    n_checks++; if (cpbf !== 32'h222 || flag !== 1'b0)
      begin n_fail++; $display("FAIL stale_ignored got %h/%b want 222/0", cpbf, flag); end
  endtask

  task automatic test_random();
    bit rose, ok_sweep;
    int n_upd, lat, mode;
    logic          exp_flag  = 1'b0;
    logic [DW-1:0] exp_cpbf  = 32'h222;
    logic          exp_alarm;
    logic [DW-1:0] d0, d1;
    exp_alarm = model_alarm(32'h110, 32'h222, threshold);
    for (int it = 0; it < 10; it++) begin
      d0 = $urandom;
      d1 = ($urandom_range(0, 3) == 0) ? 32'h0 : DW'($urandom_range(1, 255));
      threshold = DW'($urandom_range(0, 300));
      mode = $urandom_range(0, 2);
      mem[0] = d0; mem[1] = d1;
      resp_mode = (mode == 0) ? 0 : 2;
      err_addr  = (mode == 2) ? 1 : 0;
      ok_sweep  = (mode == 0);
      if (ok_sweep) begin
        exp_flag = d0[0]; exp_cpbf = d1; exp_alarm = model_alarm(d0, d1, threshold);
      end
      do_sweep(rose, n_upd, lat);
      n_checks++; if (n_upd != (ok_sweep ? 1 : 0) || (ok_sweep && lat != 7))
        begin n_fail++; $display("FAIL rnd%0d_update got n=%0d lat=%0d want %0d/7", it, n_upd, lat, ok_sweep); end
      n_checks++; if (flag !== exp_flag || cpbf !== exp_cpbf || alarm !== exp_alarm)
        begin n_fail++; $display("FAIL rnd%0d_snapshot got %b/%h/%b want %b/%h/%b", it, flag, cpbf, alarm, exp_flag, exp_cpbf, exp_alarm); end
      n_checks++; if (bus_err !== !ok_sweep)
        begin n_fail++; $display("FAIL rnd%0d_bus_err got %b want %b", it, bus_err, !ok_sweep); end
      pulse_clr();
    end
    resp_mode = 0;
  endtask

  task automatic test_start_drop_and_reset();
    bit ok;
    int ups, late;
    mem[0] = 32'h0; mem[1] = 32'h55; threshold = 32'h50; period = 16'd2;
    start = 1'b1;
    wait_valid(10, ok);
    start = 1'b0;
    ups = 0; late = 0;
    repeat (40) begin
      @(negedge clk);
      if (update === 1'b1) ups++;
      else if (ups > 0 && valid === 1'b1) late++;
    end
    n_checks++; if (!ok || ups != 1) begin n_fail++; $display("FAIL drop_updates got %0d want 1", ups); end
    n_checks++; if (late != 0)       begin n_fail++; $display("FAIL drop_idle got %0d req cycles want 0", late); end
    n_checks++; if (cpbf !== 32'h55) begin n_fail++; $display("FAIL drop_cpbf got %h want 55", cpbf); end
    start = 1'b1;
    wait_valid(10, ok);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", valid); end
    n_checks++; if (cpbf !== '0 || flag !== 1'b0 || alarm !== 1'b0 || bus_err !== 1'b0 || update !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_outputs got %h/%b/%b/%b/%b want 0", cpbf, flag, alarm, bus_err, update); end
    start = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL rst_after_valid got %b want 0", valid); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_alarm_cases();
    test_error();
    test_timeout();
    test_both_and_stale();
    test_random();
    test_start_drop_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
